// File: rtl/gray_count_pkg.sv
// Shared types and helpers for the Gray-coded count tracker.
package gray_count_pkg;

    // Tracker state: whether a reference sample is held.
    typedef enum logic {
        EMPTY  = 1'b0,
        PRIMED = 1'b1
    } track_state_e;

    // Widest vector popcount accepts; narrower callers zero-extend.
    localparam int unsigned POP_MAX_W = 64;

    // Number of set bits in v.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < int'(POP_MAX_W); i++) begin
            cnt = cnt + 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/Gray_to_Binary.sv
// Combinational Gray-to-binary converter.
module Gray_to_Binary #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] binary_out
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        assign binary_out[i] = ^gray_in[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_count_tracker.sv
// Receive-side Gray count tracker: converts samples, reports step and flags multi-bit jumps.
module gray_count_tracker
    import gray_count_pkg::*;
#(
    parameter int unsigned WIDTH             = 4,
    parameter bit          CHECK_SINGLE_STEP = 1'b1
) (
    input  logic             clk,
    input  logic             sresetn,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             gray_in_valid,
    input  logic             error_clear,
    output logic [WIDTH-1:0] binary_out,
    output logic             binary_out_valid,
    output logic [WIDTH-1:0] delta,
    output logic             wrapped,
    output logic             step_error,
    output logic             error_sticky,
    output logic             primed
);

    track_state_e     state_q, state_d;
    logic [WIDTH-1:0] gray_last_q, gray_last_d;
    logic [WIDTH-1:0] bin_last_q, bin_last_d;
    logic [WIDTH-1:0] delta_q, delta_d;
    logic             valid_q, valid_d;
    logic             wrapped_q, wrapped_d;
    logic             step_error_q, step_error_d;
    logic             error_sticky_q, error_sticky_d;
    logic             primed_q, primed_d;

    logic [WIDTH-1:0] bin_new;
    int unsigned      bit_flips;

    Gray_to_Binary #(.WIDTH(WIDTH)) u_g2b (
        .gray_in    (gray_in),
        .binary_out (bin_new)
    );

    // Bits changed between the incoming sample and the held reference.
    assign bit_flips = popcount(POP_MAX_W'(gray_in ^ gray_last_q));

    // Next-state, reference update, step/wrap/error evaluation.
    always_comb begin
        state_d        = state_q;
        gray_last_d    = gray_last_q;
        bin_last_d     = bin_last_q;
        delta_d        = delta_q;
        valid_d        = 1'b0;
        wrapped_d      = 1'b0;
        step_error_d   = 1'b0;

        if (gray_in_valid) begin
            valid_d     = 1'b1;
            gray_last_d = gray_in;
            bin_last_d  = bin_new;
            state_d     = PRIMED;
            case (state_q)
                EMPTY: begin
                    delta_d = '0;
                end
                PRIMED: begin
                    delta_d      = bin_new - bin_last_q;
                    wrapped_d    = (bin_last_q == '1) && (bin_new == '0);
                    step_error_d = CHECK_SINGLE_STEP && (bit_flips > 32'd1);
                end
                default: begin
                    delta_d = '0;
                end
            endcase
        end

        // Set wins over a simultaneous clear.
        error_sticky_d = step_error_d | (error_sticky_q & ~error_clear);
        primed_d       = (state_d == PRIMED);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q        <= EMPTY;
            gray_last_q    <= '0;
            bin_last_q     <= '0;
            delta_q        <= '0;
            valid_q        <= 1'b0;
            wrapped_q      <= 1'b0;
            step_error_q   <= 1'b0;
            error_sticky_q <= 1'b0;
            primed_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            gray_last_q    <= gray_last_d;
            bin_last_q     <= bin_last_d;
            delta_q        <= delta_d;
            valid_q        <= valid_d;
            wrapped_q      <= wrapped_d;
            step_error_q   <= step_error_d;
            error_sticky_q <= error_sticky_d;
            primed_q       <= primed_d;
        end
    end

    assign binary_out       = bin_last_q;
    assign binary_out_valid = valid_q;
    assign delta            = delta_q;
    assign wrapped          = wrapped_q;
    assign step_error       = step_error_q;
    assign error_sticky     = error_sticky_q;
    assign primed           = primed_q;

endmodule

// File: tb/tb_gray_count_tracker.sv
// Scoreboard bench for gray_count_tracker: checked and unchecked instances share stimulus.
module tb_gray_count_tracker;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] bin;
        logic [W-1:0] delta;
        logic         valid;
        logic         wrapped;
        logic         err;
        logic         sticky;
        logic         primed;
    } exp_t;

    logic         clk = 1'b0;
    logic         sresetn = 1'b0;
    logic [W-1:0] gray_in = '0;
    logic         gray_in_valid = 1'b0;
    logic         error_clear = 1'b0;

    logic [W-1:0] a_bin, a_delta, b_bin, b_delta;
    logic         a_valid, a_wrapped, a_err, a_sticky, a_primed;
    logic         b_valid, b_wrapped, b_err, b_sticky, b_primed;

    int n_vec = 0;
    int n_err = 0;

    exp_t sb_q[$];

    // Reference model state
    logic         m_primed = 1'b0;
    logic [W-1:0] m_gray = '0;
    logic [W-1:0] m_bin = '0;
    logic [W-1:0] m_delta = '0;
    logic         m_sticky = 1'b0;

    always #5 clk = ~clk;

    gray_count_tracker #(.WIDTH(W), .CHECK_SINGLE_STEP(1'b1)) u_dut_chk (
        .clk(clk), .sresetn(sresetn), .gray_in(gray_in), .gray_in_valid(gray_in_valid),
        .error_clear(error_clear), .binary_out(a_bin), .binary_out_valid(a_valid),
        .delta(a_delta), .wrapped(a_wrapped), .step_error(a_err),
        .error_sticky(a_sticky), .primed(a_primed)
    );

    gray_count_tracker #(.WIDTH(W), .CHECK_SINGLE_STEP(1'b0)) u_dut_nochk (
        .clk(clk), .sresetn(sresetn), .gray_in(gray_in), .gray_in_valid(gray_in_valid),
        .error_clear(error_clear), .binary_out(b_bin), .binary_out_valid(b_valid),
        .delta(b_delta), .wrapped(b_wrapped), .step_error(b_err),
        .error_sticky(b_sticky), .primed(b_primed)
    );

    function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and push the model's expectation.
    task automatic step(input logic rst_n_i, input logic vld, input logic [W-1:0] g, input logic clr);
        exp_t e;
        logic [W-1:0] nb;
        @(negedge clk);
        sresetn       = rst_n_i;
        gray_in_valid = vld;
        gray_in       = g;
        error_clear   = clr;
        e = '0;
        if (!rst_n_i) begin
            m_primed = 1'b0; m_gray = '0; m_bin = '0; m_delta = '0; m_sticky = 1'b0;
        end else if (vld) begin
            nb = gray2bin(g);
            e.valid = 1'b1;
            if (m_primed) begin
                m_delta   = nb - m_bin;
                e.wrapped = (m_bin == 4'hF) && (nb == 4'h0);
                e.err     = ($countones(g ^ m_gray) > 1);
            end else begin
                m_delta = '0;
            end
            m_sticky = e.err | (m_sticky & ~clr);
            m_bin    = nb;
            m_gray   = g;
            m_primed = 1'b1;
        end else begin
            m_sticky = m_sticky & ~clr;
        end
        e.bin    = m_bin;
        e.delta  = m_delta;
        e.sticky = m_sticky;
        e.primed = m_primed;
        sb_q.push_back(e);
    endtask

    // Compare both instances one step after each active edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("bin",       32'(a_bin),     32'(e.bin));
            check_eq("valid",     32'(a_valid),   32'(e.valid));
            check_eq("delta",     32'(a_delta),   32'(e.delta));
            check_eq("wrapped",   32'(a_wrapped), 32'(e.wrapped));
            check_eq("step_err",  32'(a_err),     32'(e.err));
            check_eq("sticky",    32'(a_sticky),  32'(e.sticky));
            check_eq("primed",    32'(a_primed),  32'(e.primed));
            check_eq("nc_bin",    32'(b_bin),     32'(e.bin));
            check_eq("nc_delta",  32'(b_delta),   32'(e.delta));
            check_eq("nc_wrap",   32'(b_wrapped), 32'(e.wrapped));
            check_eq("nc_valid",  32'(b_valid),   32'(e.valid));
            check_eq("nc_primed", 32'(b_primed),  32'(e.primed));
            check_eq("nc_err",    32'(b_err),     32'd0);
            check_eq("nc_sticky", 32'(b_sticky),  32'd0);
        end
    end

    initial begin
        logic [W-1:0] g;
        int wrap_seen;

        // Reset
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);

        // First sample primes the tracker
        step(1'b1, 1'b1, 4'b0110, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0);

        // Counting sequence through a wrap
        step(1'b0, 1'b0, 4'h0, 1'b0);
        for (int b = 0; b < 20; b++) begin
            g = bin2gray(4'(b));
            step(1'b1, 1'b1, g, 1'b0);
        end
        step(1'b1, 1'b0, 4'h0, 1'b0);

        // Multi-bit jump forward, then a step back
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'b0110, 1'b0);
        step(1'b1, 1'b1, 4'b0101, 1'b0);
        step(1'b1, 1'b1, 4'b0111, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0);

        // Down step and repeat
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'b0110, 1'b0);
        step(1'b1, 1'b1, 4'b0010, 1'b0);
        step(1'b1, 1'b1, 4'b0010, 1'b0);

        // Clear coincident with an error, then clear alone
        step(1'b1, 1'b1, 4'b1000, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b0);

        // Reset mid-stream with valid high, then re-prime far away
        step(1'b1, 1'b1, 4'b1001, 1'b0);
        step(1'b0, 1'b1, 4'b1111, 1'b0);
        step(1'b1, 1'b1, 4'b1010, 1'b0);
        step(1'b1, 1'b1, 4'b0101, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0);

        // Random samples with occasional clears and idles
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 7) == 0));
        end

        step(1'b1, 1'b0, 4'h0, 1'b0);
        wrap_seen = 0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
